// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared state encoding and width constants for the XOR correlation sequencer
//
// Contents:
//   C_WORD_W    width of the sample words and of the pop-count interface
//   C_RESULT_W  width of the frame correlation result
//   C_SUM_W     number of pop-count result bits actually consumed (0..128)
//   state_t     sequencer state encoding
package corr_pkg;

    localparam int C_WORD_W   = 128;
    localparam int C_RESULT_W = 32;
    localparam int C_SUM_W    = 8;

    typedef enum logic [2:0] {
        S_ACCEPT = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_ACCUM  = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

endpackage

// File: rtl/xor_corr_sequencer.sv
// rtl/xor_corr_sequencer.sv - frame sequencer that correlates sample words through an external pop-count stage
//
// Accepts one word pair at a time, hands a^b to the neighbouring pop-count stage,
// waits a fixed latency for its result, and accumulates the per-word counts over a
// frame of i_num_words words before presenting the frame result.
//
// Configuration macro: CORR_SIGNED_EN
//   undefined : o_result = accumulated disagreeing-bit count, zero-extended
//   defined   : o_result = agreeing bits minus disagreeing bits (N*128 - 2*acc), sign-extended
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_a, i_b                  sample words to correlate
//   i_valid / o_ready         word handshake; i_num_words sampled on the first word of a frame
//   i_num_words               words per frame (0 behaves as 1)
//   o_pc_start, o_pc_data     one-cycle launch pulse and XOR word to the pop-count stage
//   i_pc_sum                  pop-count result, bits [7:0] used
//   o_result, o_result_valid  frame result, held until i_result_ready
//   i_result_ready            consumer accepts o_result
//   o_busy                    sequencer not idle or a frame partially accumulated
module xor_corr_sequencer
    import corr_pkg::*;
#(
    parameter int C_PC_LATENCY = 9,
    parameter int C_NWORDS_W   = 16,
    parameter int C_ACC_W      = 24
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [C_WORD_W-1:0]   i_a,
    input  logic [C_WORD_W-1:0]   i_b,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [C_NWORDS_W-1:0] i_num_words,
    output logic                  o_pc_start,
    output logic [C_WORD_W-1:0]   o_pc_data,
    input  logic [C_WORD_W-1:0]   i_pc_sum,
    output logic [C_RESULT_W-1:0] o_result,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output logic                  o_busy
);

    // The wait counter only has to reach C_PC_LATENCY-2: S_WAIT lasts
    // C_PC_LATENCY-1 cycles so that S_ACCUM lands exactly C_PC_LATENCY
    // cycles after the launch cycle.
    localparam int CNT_W = (C_PC_LATENCY > 2) ? $clog2(C_PC_LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST =
        CNT_W'((C_PC_LATENCY >= 2) ? (C_PC_LATENCY - 2) : 0);

    state_t                  state;
    logic [C_NWORDS_W-1:0]   num_words;
    logic [C_NWORDS_W-1:0]   word_cnt;
    logic [C_ACC_W-1:0]      acc;
    logic [CNT_W-1:0]        wait_cnt;

    logic [C_ACC_W-1:0]      acc_next;
    logic [C_NWORDS_W-1:0]   word_cnt_next;
    logic [C_RESULT_W-1:0]   result_next;
    logic                    unused_pc_hi;

    // Only the low byte of the pop-count bus carries the 0..128 count.
    assign unused_pc_hi  = ^i_pc_sum[C_WORD_W-1:C_SUM_W];
    assign acc_next      = acc + {{(C_ACC_W-C_SUM_W){1'b0}}, i_pc_sum[C_SUM_W-1:0]};
    assign word_cnt_next = word_cnt + 1'b1;

`ifdef CORR_SIGNED_EN
    // Agreeing minus disagreeing bits: N*128 - 2*acc. One extra bit of headroom
    // keeps both the full-scale term and 2*acc representable before the subtract.
    logic [C_ACC_W:0] full_scale;
    logic [C_ACC_W:0] signed_diff;

    assign full_scale  = (C_ACC_W+1)'({num_words, 7'b0});
    assign signed_diff = full_scale - {acc_next, 1'b0};
    assign result_next = {{(C_RESULT_W-C_ACC_W-1){signed_diff[C_ACC_W]}}, signed_diff};
`else
    assign result_next = {{(C_RESULT_W-C_ACC_W){1'b0}}, acc_next};
`endif

    assign o_busy = (state != S_ACCEPT) || (word_cnt != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= S_ACCEPT;
            num_words      <= '0;
            word_cnt       <= '0;
            acc            <= '0;
            wait_cnt       <= '0;
            o_ready        <= 1'b0;
            o_pc_start     <= 1'b0;
            o_pc_data      <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else begin
            case (state)
                S_ACCEPT: begin
                    // o_ready is registered, so it is still low in the first
                    // cycle after reset; gating on it keeps that cycle idle.
                    if (o_ready && i_valid) begin
                        o_pc_data <= i_a ^ i_b;
                        if (word_cnt == '0) begin
                            num_words <= (i_num_words == '0) ? C_NWORDS_W'(1) : i_num_words;
                        end
                        o_ready    <= 1'b0;
                        o_pc_start <= 1'b1;
                        state      <= S_LAUNCH;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end

                S_LAUNCH: begin
                    o_pc_start <= 1'b0;
                    wait_cnt   <= '0;
                    if (C_PC_LATENCY <= 1) begin
                        state <= S_ACCUM;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_ACCUM;
                    end
                end

                S_ACCUM: begin
                    acc      <= acc_next;
                    word_cnt <= word_cnt_next;
                    if (word_cnt_next == num_words) begin
                        o_result       <= result_next;
                        o_result_valid <= 1'b1;
                        state          <= S_OUTPUT;
                    end else begin
                        o_ready <= 1'b1;
                        state   <= S_ACCEPT;
                    end
                end

                S_OUTPUT: begin
                    // o_result keeps its value after acceptance; only the
                    // valid flag and the frame accumulators are cleared.
                    if (i_result_ready) begin
                        acc            <= '0;
                        word_cnt       <= '0;
                        o_result_valid <= 1'b0;
                        o_ready        <= 1'b1;
                        state          <= S_ACCEPT;
                    end
                end

                default: begin
                    acc            <= '0;
                    word_cnt       <= '0;
                    o_pc_start     <= 1'b0;
                    o_result_valid <= 1'b0;
                    o_ready        <= 1'b0;
                    state          <= S_ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_corr_sequencer.sv
// tb/tb_xor_corr_sequencer.sv - directed self-checking bench for xor_corr_sequencer
module tb_xor_corr_sequencer;

    localparam int LAT = 9;

    logic          clk = 1'b0;
    logic          i_reset;
    logic [127:0]  i_a, i_b;
    logic          i_valid;
    logic          o_ready;
    logic [15:0]   i_num_words;
    logic          o_pc_start;
    logic [127:0]  o_pc_data;
    logic [127:0]  i_pc_sum;
    logic [31:0]   o_result;
    logic          o_result_valid;
    logic          i_result_ready;
    logic          o_busy;

    int checks    = 0;
    int failures  = 0;
    int pc_starts = 0;
    int pc_cnt    = 0;

    always #5 clk = ~clk;

    xor_corr_sequencer dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_a            (i_a),
        .i_b            (i_b),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_num_words    (i_num_words),
        .o_pc_start     (o_pc_start),
        .o_pc_data      (o_pc_data),
        .i_pc_sum       (i_pc_sum),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_busy         (o_busy)
    );

    // Pop-count stage model: garbage until LAT cycles after the launch cycle,
    // then the true count in [7:0] with junk in the unused upper bits.
    always @(posedge clk) begin
        if (o_pc_start === 1'b1) begin
            pc_starts <= pc_starts + 1;
            pc_cnt    <= 1;
            i_pc_sum  <= {120'h5A5A_0000_1234_5678_9ABC_DEF0_1357, 8'hC8};
        end else if (pc_cnt != 0 && pc_cnt < LAT) begin
            pc_cnt <= pc_cnt + 1;
            if (pc_cnt + 1 == LAT) begin
                i_pc_sum <= {120'hF0F0_0000_AAAA_5555_1111_2222_3333, 8'($countones(o_pc_data))};
            end
        end
    end

    function automatic logic [31:0] exp_res(input int n, input int acc);
`ifdef CORR_SIGNED_EN
        return 32'(n * 128 - 2 * acc);
`else
        return 32'(acc);
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [127:0] a, input logic [127:0] b,
                             input logic [15:0] n, input bit do_chk);
        int k = 0;
        while (o_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("send_ready_timeout", 128'(o_ready), 128'd1);
        i_a = a; i_b = b; i_num_words = n; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        if (do_chk) begin
            chk("pc_start_pulse", 128'(o_pc_start), 128'd1);
            chk("pc_data", o_pc_data, a ^ b);
            chk("ready_low_launch", 128'(o_ready), 128'd0);
        end
    endtask

    task automatic count_ready_low(output int k);
        k = 0;
        while (o_ready !== 1'b1 && k < 100) begin
            k++;
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (o_result_valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("result_timeout", 128'(o_result_valid), 128'd1);
    endtask

    task automatic accept_result();
        i_result_ready = 1'b1;
        @(negedge clk);
        i_result_ready = 1'b0;
        chk("valid_cleared", 128'(o_result_valid), 128'd0);
        chk("busy_idle", 128'(o_busy), 128'd0);
        chk("ready_back", 128'(o_ready), 128'd1);
    endtask

    initial begin
        int k;
        int s0;
        bit seen;
        logic [31:0] held;

        i_reset = 1'b1; i_a = '0; i_b = '0; i_valid = 1'b0;
        i_num_words = '0; i_result_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ready", 128'(o_ready), 128'd0);
        chk("rst_pc_start", 128'(o_pc_start), 128'd0);
        chk("rst_pc_data", o_pc_data, 128'd0);
        chk("rst_result", 128'(o_result), 128'd0);
        chk("rst_valid", 128'(o_result_valid), 128'd0);
        chk("rst_busy", 128'(o_busy), 128'd0);
        i_reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 128'(o_ready), 128'd1);

        // N=1, all-ones vs zero: full disagreement, exact latency
        s0 = pc_starts;
        send_word({128{1'b1}}, 128'd0, 16'd1, 1'b1);
        wait_valid(k);
        chk("latency_n1", 128'(k), 128'd10);
        chk("result_n1", 128'(o_result), 128'(exp_res(1, 128)));
        chk("one_pc_start", 128'(pc_starts - s0), 128'd1);
        accept_result();

        // N=4, a==b: no disagreeing bits; o_ready low from accept to S_ACCUM
        for (int w = 0; w < 4; w++) begin
            send_word(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 + 128'(w * 77),
                      128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 + 128'(w * 77),
                      16'd4, 1'b1);
            if (w < 3) begin
                count_ready_low(k);
                chk("ready_low_span", 128'(k), 128'd10);
                chk("busy_partial", 128'(o_busy), 128'd1);
            end
        end
        wait_valid(k);
        chk("latency_n4_last", 128'(k), 128'd10);
        chk("result_n4", 128'(o_result), 128'(exp_res(4, 0)));
        accept_result();

        // N=0 behaves as a one-word frame, a^b = 0x0F
        send_word(128'h0F, 128'h00, 16'd0, 1'b1);
        wait_valid(k);
        chk("result_n0", 128'(o_result), 128'(exp_res(1, 4)));
        accept_result();

        // back-pressure: result held for 5 cycles, no word accepted meanwhile
        send_word(128'h1F, 128'h00, 16'd1, 1'b0);
        wait_valid(k);
        held = o_result;
        chk("bp_result", 128'(held), 128'(exp_res(1, 5)));
        s0 = pc_starts;
        i_a = 128'hFF; i_b = 128'h0; i_num_words = 16'd1; i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_held", 128'(o_result_valid), 128'd1);
            chk("bp_result_held", 128'(o_result), 128'(held));
            chk("bp_ready_low", 128'(o_ready), 128'd0);
        end
        i_result_ready = 1'b1;
        @(negedge clk);
        i_result_ready = 1'b0;
        i_valid = 1'b0;
        chk("bp_accepted", 128'(o_result_valid), 128'd0);
        chk("bp_no_launch", 128'(pc_starts - s0), 128'd0);
        @(negedge clk);

        // reset in S_WAIT of word 2 of an N=3 frame abandons the frame
        send_word(128'h7, 128'h0, 16'd3, 1'b0);
        count_ready_low(k);
        send_word(128'h3, 128'h0, 16'd3, 1'b0);
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("midrst_busy", 128'(o_busy), 128'd0);
        chk("midrst_valid", 128'(o_result_valid), 128'd0);
        chk("midrst_ready", 128'(o_ready), 128'd0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_result_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_result", 128'(seen), 128'd0);
        send_word(128'h7F, 128'h0, 16'd1, 1'b1);
        wait_valid(k);
        chk("result_after_rst", 128'(o_result), 128'(exp_res(1, 7)));
        accept_result();

        // long frame: accumulator carries well past 16 bits without wrap
        for (int w = 0; w < 3000; w++) begin
            send_word({128{1'b1}}, 128'd0, 16'd3000, 1'b0);
        end
        wait_valid(k);
        chk("result_long", 128'(o_result), 128'(exp_res(3000, 384000)));
        accept_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_corr_sequencer.md
XOR_CORR_SEQUENCER -- requirements
Module: xor_corr_sequencer

Interface
REQ-001 Parameter C_PC_LATENCY, default 9: cycles from the o_pc_start pulse to i_pc_sum holding the final pop count.
REQ-002 Parameter C_NWORDS_W, default 16: width of the frame word-count input.
REQ-003 Parameter C_ACC_W, default 24: internal accumulator width.
REQ-004 i_clk  in  1  clock; all logic on its rising edge.
REQ-005 i_reset  in  1  reset, synchronous, active-high.
REQ-006 i_a, i_b  in  128 each  sample words to correlate.
REQ-007 i_valid  in  1  i_a/i_b/i_num_words valid.
REQ-008 o_ready  out  1  block accepts a word this cycle.
REQ-009 i_num_words  in  C_NWORDS_W  words per frame; sampled with the first word of each frame only.
REQ-010 o_pc_start  out  1  one-cycle launch pulse to the pop-count stage.
REQ-011 o_pc_data  out  128  XOR word driven to the pop-count stage.
REQ-012 i_pc_sum  in  128  pop-count result; only bits [7:0] are used.
REQ-013 o_result  out  32  frame correlation result.
REQ-014 o_result_valid  out  1  o_result valid; held until accepted.
REQ-015 i_result_ready  in  1  consumer accepts o_result.
REQ-016 o_busy  out  1  high whenever state is not S_ACCEPT or a frame is partially accumulated.

Function
REQ-017 FSM states: S_ACCEPT, S_LAUNCH, S_WAIT, S_ACCUM, S_OUTPUT.
REQ-018 S_ACCEPT: o_ready=1; on i_valid, latch i_a^i_b into o_pc_data and go to S_LAUNCH; otherwise stay.
REQ-019 First word of a frame latches i_num_words; value 0 is treated as 1.
REQ-020 S_LAUNCH: o_pc_start=1 for exactly one cycle; clear wait counter; go to S_WAIT.
REQ-021 S_WAIT: increment wait counter each cycle; go to S_ACCUM when the counter reaches C_PC_LATENCY-1, so i_pc_sum is sampled C_PC_LATENCY cycles after the o_pc_start cycle.
REQ-022 o_pc_data stays stable from S_LAUNCH through S_ACCUM.
REQ-023 S_ACCUM: acc += i_pc_sum[7:0], word counter +1; go to S_OUTPUT if word counter equals the latched count, else go to S_ACCEPT.
REQ-024 o_ready=0 in every state except S_ACCEPT; one word is in flight at a time.
REQ-025 S_OUTPUT: o_result_valid=1 with o_result stable; on i_result_ready, clear acc and word counter and go to S_ACCEPT.
REQ-026 Arithmetic: per-word sum is 0..128, zero-extended; acc is unsigned with no saturation (the 16-bit count times 128 fits in 24 bits); o_result is acc zero-extended to 32 bits.
REQ-027 Illegal state encoding: go to S_ACCEPT and clear acc and word counter.

Reset
REQ-028 i_reset in any state, including mid-frame or mid-wait, forces S_ACCEPT and abandons the partial frame.
REQ-029 Reset values: o_ready=0 during the reset cycle then 1; o_pc_start=0; o_pc_data=0; o_result=0; o_result_valid=0; o_busy=0; acc, word counter and wait counter =0.

Configuration
REQ-030 Macro CORR_SIGNED_EN defined: o_result = sign-extended two's-complement (N*128 - 2*acc), i.e. agreeing bits minus disagreeing bits, using a 25-bit intermediate.
REQ-031 Macro CORR_SIGNED_EN undefined: o_result = unsigned acc per REQ-026, and the signed logic is absent.

Structure
REQ-032 Shared package corr_pkg holds the state encoding, the 128-bit word width constant and the result width constant.
REQ-033 No sub-module; the pop-count stage is instantiated beside this block at the core level, not inside it.

Verification
REQ-034 N=1, a=all-ones, b=0, pop-count model returns 128 after 9 cycles -> o_result=128 (signed build: -128), o_pc_start pulses once.
REQ-035 N=4, a=b in every word -> o_result=0 (signed build: 512); o_ready low from each accept until the following S_ACCUM.
REQ-036 N=0 with one word a^b=0x0F -> frame of one word, o_result=4.
REQ-037 i_result_ready held low for 5 cycles -> o_result_valid and o_result stable for those cycles, no new word accepted; accepted on cycle 6.
REQ-038 i_reset asserted in S_WAIT of word 2 of an N=3 frame -> no o_result_valid; the next frame of N=1 with sum 7 gives o_result=7.
REQ-039 N=65535 with every sum 128 -> o_result=8388480 with no wrap (signed build: -8388480).
